mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multicycle control unit for the 16-bit datapath. A Moore state machine decodes the 4-bit opcode latched in the instruction register and sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives every register write enable and every datapath multiplexer select, including the 2-bit selects of the 4-input 16-bit muxes in front of the ALU, PC and register-file write port. It also counts retired instructions.

## Interface
- No parameters; all widths are fixed by the ISA.
- clock  in  1  rising-edge system clock
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock
- opcode  in  4  instruction bits [15:12] from the instruction register
- zero  in  1  ALU zero flag, valid combinationally in the BRANCH state
- pc_write  out  1  unconditional PC load
- ir_write  out  1  instruction register load
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- reg_write  out  1  register-file write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  0 = register B, 1 = constant 2, 2 = sign-extended imm, 3 = imm<<1
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = PC (hold)
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link), 3 = zero
- reg_dst  out  1  0 = rt field, 1 = rd field
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 PASS_B
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- retired  out  16  retired-instruction count
- state  out  4  current state encoding, for debug

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR (R-type); 4 ADDI; 5 LW; 6 SW; 7 BEQ; 8 J; 9 JAL; F HALT. The encodings A–E are illegal.
- States and encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_MEM 8, BRANCH 9, JUMP 10, HALT 11.
- FETCH: mem_read=1, iord=0, ir_write=1, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0, pc_write=1. The next state is DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD (branch target into ALUOut). The next state depends on the opcode:
  - 0–3 go to EXEC_R.
  - 4 goes to EXEC_I.
  - 5 and 6 go to MEM_ADDR.
  - 7 goes to BRANCH.
  - 8 and 9 go to JUMP.
  - F goes to HALT.
  - Illegal opcodes go to FETCH with instr_done=1, so they retire as NOPs.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=opcode[2:0]. The next state is WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=ADD. The next state is WB_R.
- WB_R: reg_write=1, mem_to_reg=0, reg_dst = 1 for R-type and 0 for ADDI. Sets instr_done. The next state is FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=ADD. The next state is MEM_RD for LW and MEM_WR for SW.
- MEM_RD: mem_read=1, iord=1. The next state is WB_MEM.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0. Sets instr_done. The next state is FETCH.
- MEM_WR: mem_write=1, iord=1. Sets instr_done. The next state is FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=SUB, pc_src=1, pc_write=zero. Sets instr_done. The next state is FETCH.
- JUMP: pc_src=2, pc_write=1. For JAL also reg_write=1, mem_to_reg=2, reg_dst=0. Sets instr_done. The next state is FETCH.
- HALT: all enables are 0 and pc_src=3. The FSM stays in HALT until reset. instr_done pulses once on entry to HALT.
- Any output not listed for a state is 0.
- retired increments on every cycle where instr_done=1 and wraps from 0xFFFF to 0x0000.

## Timing
- State and retired update on the rising edge of clock. All outputs except retired and state are combinational decodes of the state register (Moore). The one exception is BRANCH's pc_write, which also depends on zero.
- Instruction latency in cycles:
  - R-type and ADDI: 4.
  - LW: 5.
  - SW: 4.
  - BEQ, J and JAL: 3.
  - Illegal opcode: 2.
- Reset behaviour:
  - While reset=1, every write enable and strobe is forced to 0: pc_write, ir_write, mem_read, mem_write, reg_write, instr_done.
  - On the edge where reset=1: state becomes FETCH and retired becomes 0. There is no other reset value; all other outputs are decodes of FETCH.
  - A reset asserted mid-instruction abandons that instruction with no write enable asserted, and the instruction is not counted.

## Configuration
- Macro: MC_CTRL_HALT_EN.
- When defined, opcode F enters HALT as described above.
- When undefined, the HALT state is not built and opcode F is handled as an illegal opcode: DECODE goes to FETCH with instr_done=1.

## Structure
- The shared package holds:
  - the opcode constants;
  - the state encodings;
  - the alu_op codes;
  - the mux-select constants for alu_src_b, pc_src and mem_to_reg, which are shared with the 4-input 16-bit mux instances.
- One sub-module, mc_ctrl_decode, is natural: a purely combinational map from state, opcode and zero to the output vector. The top level holds only the state register, the next-state logic and the retired counter.

## Test plan
- Reset held for 2 cycles, then released with opcode=0 → state=FETCH, retired=0, all enables 0 during reset, ir_write=1 on the first cycle after release.
- ADD (opcode 0) → states FETCH→DECODE→EXEC_R→WB_R; reg_write=1 and reg_dst=1 only in cycle 4; retired=1.
- LW (5) followed by SW (6) → 5 + 4 cycles; mem_read=1 with iord=1 in MEM_RD; mem_write=1 only in MEM_WR; retired=2.
- BEQ (7): with zero=1, pc_write=1 and pc_src=1 in cycle 3; with zero=0, pc_write=0. JAL (9) → reg_write=1, mem_to_reg=2, pc_src=2.
- Opcode F:
  - with MC_CTRL_HALT_EN defined → state=11 after DECODE and held for 100 cycles with no enables, retired incremented once;
  - without the macro → back to FETCH after 2 cycles.
- Preload the counter by running 65535 ADDIs, then retire one more instruction → retired wraps 0xFFFF→0x0000. Assert reset in MEM_RD → no reg_write, next state FETCH.

Source files
------------

// File: rtl/mc_control_fsm_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, states, ALU codes and mux selects.
// HALT support is selected by the MC_CTRL_HALT_EN macro in the files that import this package.
`default_nettype none

package mc_control_fsm_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_JAL  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_PASS_B = 3'd4;

  // Selects for the 4-input 16-bit muxes feeding the ALU B port, PC and write port.
  localparam logic [1:0] SRC_B_REG     = 2'd0;
  localparam logic [1:0] SRC_B_TWO     = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] SRC_B_IMM_SHL = 2'd3;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_HOLD   = 2'd3;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_LINK   = 2'd2;
  localparam logic [1:0] M2R_ZERO   = 2'd3;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic       reg_dst;
    logic [2:0] alu_op;
    logic       instr_done;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return op <= OP_OR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// Combinational map from state/opcode/zero to the control vector.
// MC_CTRL_HALT_EN adds the HALT state decode (PC held).
`default_nettype none

module mc_ctrl_decode
  import mc_control_fsm_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       zero,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRC_B_TWO;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PC_SRC_ALU;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRC_B_IMM_SHL;
        ctrl.alu_op     = ALU_ADD;
        // Opcodes above JAL finish here: illegal ones retire as NOPs, HALT retires on entry.
        ctrl.instr_done = (opcode > OP_JAL);
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = opcode[2:0];
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_WB_R: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.reg_dst    = is_rtype(opcode);
        ctrl.instr_done = 1'b1;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = 1'b1;
        ctrl.alu_src_b  = SRC_B_REG;
        ctrl.alu_op     = ALU_SUB;
        ctrl.pc_src     = PC_SRC_ALUOUT;
        ctrl.pc_write   = zero;
        ctrl.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src     = PC_SRC_JUMP;
        ctrl.pc_write   = 1'b1;
        ctrl.instr_done = 1'b1;
        if (opcode == OP_JAL) begin
          ctrl.reg_write  = 1'b1;
          ctrl.mem_to_reg = M2R_LINK;
        end
      end
`ifdef MC_CTRL_HALT_EN
      S_HALT: ctrl.pc_src = PC_SRC_HOLD;
`else
      S_HALT: ctrl = '0;
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_control_fsm.sv
// Multicycle control unit: state register, next-state logic and retired-instruction counter.
// Define MC_CTRL_HALT_EN to build the HALT state for opcode F; otherwise F retires as a NOP.
`default_nettype none

module mc_control_fsm
  import mc_control_fsm_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        zero,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        iord,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_src,
  output logic [1:0]  mem_to_reg,
  output logic        reg_dst,
  output logic [2:0]  alu_op,
  output logic        instr_done,
  output logic [15:0] retired,
  output logic [3:0]  state
);

  state_t      state_q;
  state_t      state_d;
  ctrl_t       ctrl;
  logic [15:0] retired_q;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        if (is_rtype(opcode)) begin
          state_d = S_EXEC_R;
        end else begin
          case (opcode)
            OP_ADDI:       state_d = S_EXEC_I;
            OP_LW, OP_SW:  state_d = S_MEM_ADDR;
            OP_BEQ:        state_d = S_BRANCH;
            OP_J, OP_JAL:  state_d = S_JUMP;
`ifdef MC_CTRL_HALT_EN
            OP_HALT:       state_d = S_HALT;
`else
            OP_HALT:       state_d = S_FETCH;
`endif
            default:       state_d = S_FETCH;
          endcase
        end
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_R;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
`ifdef MC_CTRL_HALT_EN
      S_HALT:     state_d = S_HALT;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .zero   (zero),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clock) begin
    if (reset)                retired_q <= 16'h0000;
    else if (ctrl.instr_done) retired_q <= retired_q + 16'h0001;
  end

  // Strobes are gated by reset so an abandoned instruction writes nothing.
  assign pc_write   = ctrl.pc_write   & ~reset;
  assign ir_write   = ctrl.ir_write   & ~reset;
  assign mem_read   = ctrl.mem_read   & ~reset;
  assign mem_write  = ctrl.mem_write  & ~reset;
  assign reg_write  = ctrl.reg_write  & ~reset;
  assign instr_done = ctrl.instr_done & ~reset;
  assign iord       = ctrl.iord;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign pc_src     = ctrl.pc_src;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_op     = ctrl.alu_op;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: reset, table of instruction summaries,
// random instruction stream against a per-cycle reference model, and corner sequences.
`default_nettype none

module tb_mc_control_fsm;

  localparam int FETCH = 0, DECODE = 1, EXEC_R = 2, EXEC_I = 3, MEM_ADDR = 4, MEM_RD = 5;
  localparam int MEM_WR = 6, WB_R = 7, WB_MEM = 8, BRANCH = 9, JUMP = 10, HALT = 11;

  typedef struct packed {
    logic       pcw, irw, mrd, mwr, rw, iord, asa;
    logic [1:0] asb, psrc, m2r;
    logic       rdst;
    logic [2:0] aop;
    logic       done;
  } ov_t;

  typedef int path_t[6];

  typedef struct {
    logic [3:0] op;
    logic       z;
    int         lat, pcw, rw, mw, mr;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  opcode = 4'h0;
  logic        zero = 1'b0;
  logic        pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a;
  logic [1:0]  alu_src_b, pc_src, mem_to_reg;
  logic        reg_dst, instr_done;
  logic [2:0]  alu_op;
  logic [15:0] retired;
  logic [3:0]  state;
  ov_t         act_v;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_ret = 16'h0000;

  always #5 clock = ~clock;

  mc_control_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .iord(iord), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_op(alu_op),
    .instr_done(instr_done), .retired(retired), .state(state)
  );

  assign act_v = {pc_write, ir_write, mem_read, mem_write, reg_write, iord, alu_src_a,
                  alu_src_b, pc_src, mem_to_reg, reg_dst, alu_op, instr_done};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sequence of states an instruction walks through, from the instruction-class table.
  function automatic void get_path(input logic [3:0] op, output path_t p, output int n);
    p = '{FETCH, DECODE, 0, 0, 0, 0};
    n = 2;
    if (op <= 4'd3)      begin p[2] = EXEC_R;   p[3] = WB_R;   n = 4; end
    else if (op == 4'd4) begin p[2] = EXEC_I;   p[3] = WB_R;   n = 4; end
    else if (op == 4'd5) begin p[2] = MEM_ADDR; p[3] = MEM_RD; p[4] = WB_MEM; n = 5; end
    else if (op == 4'd6) begin p[2] = MEM_ADDR; p[3] = MEM_WR; n = 4; end
    else if (op == 4'd7) begin p[2] = BRANCH;   n = 3; end
    else if (op == 4'd8 || op == 4'd9) begin p[2] = JUMP; n = 3; end
  endfunction

  function automatic ov_t exp_out(input int st, input logic [3:0] op, input logic z);
    ov_t e = '0;
    case (st)
      FETCH:    begin e.mrd = 1; e.irw = 1; e.asb = 2'd1; e.pcw = 1; end
      DECODE:   begin e.asb = 2'd3; e.done = (op > 4'd9); end
      EXEC_R:   begin e.asa = 1; e.aop = op[2:0]; end
      EXEC_I, MEM_ADDR: begin e.asa = 1; e.asb = 2'd2; end
      WB_R:     begin e.rw = 1; e.rdst = (op < 4'd4); e.done = 1; end
      MEM_RD:   begin e.mrd = 1; e.iord = 1; end
      WB_MEM:   begin e.rw = 1; e.m2r = 2'd1; e.done = 1; end
      MEM_WR:   begin e.mwr = 1; e.iord = 1; e.done = 1; end
      BRANCH:   begin e.asa = 1; e.aop = 3'd1; e.psrc = 2'd1; e.pcw = z; e.done = 1; end
      JUMP:     begin
        e.psrc = 2'd2; e.pcw = 1; e.done = 1;
        if (op == 4'd9) begin e.rw = 1; e.m2r = 2'd2; end
      end
      HALT:     e.psrc = 2'd3;
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic run_instr(input logic [3:0] op);
    path_t p;
    int    n;
    ov_t   e;
    get_path(op, p, n);
    opcode = op;
    for (int i = 0; i < n; i++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      e = exp_out(p[i], op, zero);
      check("state", 32'(state), 32'(p[i]));
      check("outputs", 32'(act_v), 32'(e));
      check("retired", 32'(retired), 32'(exp_ret));
      if (e.done) exp_ret++;
      step();
    end
  endtask

  task automatic run_count(input logic [3:0] op, input logic z,
                           output int lat, output int pcw, output int rw,
                           output int mw, output int mr);
    bit done = 0;
    lat = 0; pcw = 0; rw = 0; mw = 0; mr = 0;
    opcode = op;
    zero = z;
    for (int c = 0; c < 10 && !done; c++) begin
      #1;
      lat++;
      pcw += int'(pc_write);
      rw  += int'(reg_write);
      mw  += int'(mem_write);
      mr  += int'(mem_read);
      if (instr_done) begin done = 1; exp_ret++; end
      step();
    end
  endtask

  initial begin
    vec_t vt[$];
    int lat, pcw, rw, mw, mr;
    logic [3:0] op;

    // Expected per-instruction summary: latency, then cycles with pc_write/reg_write/mem_write/mem_read.
    vt.push_back('{4'h0, 1'b0, 4, 1, 1, 0, 1});
    vt.push_back('{4'h1, 1'b1, 4, 1, 1, 0, 1});
    vt.push_back('{4'h3, 1'b0, 4, 1, 1, 0, 1});
    vt.push_back('{4'h4, 1'b0, 4, 1, 1, 0, 1});
    vt.push_back('{4'h5, 1'b0, 5, 1, 1, 0, 2});
    vt.push_back('{4'h6, 1'b0, 4, 1, 0, 1, 1});
    vt.push_back('{4'h7, 1'b1, 3, 2, 0, 0, 1});
    vt.push_back('{4'h7, 1'b0, 3, 1, 0, 0, 1});
    vt.push_back('{4'h8, 1'b0, 3, 2, 0, 0, 1});
    vt.push_back('{4'h9, 1'b0, 3, 2, 1, 0, 1});
    vt.push_back('{4'hA, 1'b0, 2, 1, 0, 0, 1});
    vt.push_back('{4'hE, 1'b1, 2, 1, 0, 0, 1});
`ifndef MC_CTRL_HALT_EN
    vt.push_back('{4'hF, 1'b0, 2, 1, 0, 0, 1});
`endif

    // Reset held two cycles: every strobe low, FETCH, counter cleared.
    reset = 1'b1;
    opcode = 4'h0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_enables", 32'({pc_write, ir_write, mem_read, mem_write, reg_write, instr_done}), 0);
      check("rst_state", 32'(state), FETCH);
      check("rst_retired", 32'(retired), 0);
    end
    reset = 1'b0;
    #1;
    check("ir_write_after_rst", 32'(ir_write), 1);

    // Directed ADD, LW, SW, BEQ, JAL through the cycle-level model.
    run_instr(4'h0);
    check("retired_after_add", 32'(retired), 1);
    run_instr(4'h5);
    run_instr(4'h6);
    check("retired_after_lw_sw", 32'(retired), 3);
    run_instr(4'h7);
    run_instr(4'h9);

    foreach (vt[i]) begin
      run_count(vt[i].op, vt[i].z, lat, pcw, rw, mw, mr);
      check($sformatf("lat_op%0h", vt[i].op), 32'(lat), 32'(vt[i].lat));
      check($sformatf("pcw_op%0h", vt[i].op), 32'(pcw), 32'(vt[i].pcw));
      check($sformatf("rw_op%0h", vt[i].op), 32'(rw), 32'(vt[i].rw));
      check($sformatf("mw_op%0h", vt[i].op), 32'(mw), 32'(vt[i].mw));
      check($sformatf("mr_op%0h", vt[i].op), 32'(mr), 32'(vt[i].mr));
      check($sformatf("ret_op%0h", vt[i].op), 32'(retired), 32'(exp_ret));
    end

    for (int k = 0; k < 300; k++) begin
      op = 4'($urandom_range(0, 15));
`ifdef MC_CTRL_HALT_EN
      if (op == 4'hF) op = 4'hB;
`endif
      run_instr(op);
    end

    // Reset in MEM_RD abandons the LW: no write, not counted.
    opcode = 4'h5;
    step(); step(); step();
    check("in_mem_rd", 32'(state), MEM_RD);
    reset = 1'b1;
    #1;
    check("rst_mid_regwr", 32'({reg_write, mem_read, instr_done}), 0);
    step();
    reset = 1'b0;
    exp_ret = 16'h0000;
    #1;
    check("rst_mid_state", 32'(state), FETCH);
    check("rst_mid_retired", 32'(retired), 0);
    check("rst_mid_regwr2", 32'(reg_write), 0);
    step();
    check("rst_mid_decode", 32'(state), DECODE);
    opcode = 4'hA;
    step();

`ifdef MC_CTRL_HALT_EN
    run_instr(4'hF);
    for (int i = 0; i < 100; i++) begin
      check("halt_state", 32'(state), HALT);
      check("halt_outputs", 32'(act_v), 32'(exp_out(HALT, 4'hF, zero)));
      check("halt_retired", 32'(retired), 32'(exp_ret));
      zero = ~zero;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_ret = 16'h0000;
`endif

    // Counter wrap: preload near the top, then retire NOPs across 0xFFFF.
    #1;
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFE;
    run_instr(4'hB);
    check("wrap_ffff", 32'(retired), 32'h0000FFFF);
    run_instr(4'hC);
    check("wrap_0000", 32'(retired), 0);
    run_instr(4'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
